mem_sequencer: RTL

- Command front-end that sits directly upstream of the `memory` block and owns its port (m_clk, m_write, m_address, m_in, m_out).
- Accepts READ, WRITE and FILL commands on a valid/ready handshake and generates the two-phase m_clk pulse per beat.
- Returns read data on a one-cycle response strobe, replacing hand-stepped test sequences.

---
 rtl/mem_sequencer_pkg.sv | 18 +
 rtl/memory.sv | 21 ++
 rtl/mem_sequencer.sv | 96 +++++++++
 3 files changed

// File: rtl/mem_sequencer_pkg.sv
// Shared command and state encodings for the memory command sequencer.
package mem_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_FILL  = 2'd2,
    OP_NOP   = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } state_e;

endpackage

// File: rtl/memory.sv
// Single-port word memory clocked by the sequencer's m_clk pulse.
// Writes when m_write is high, otherwise registers the addressed word on m_out.
module memory #(
  parameter int MEM_SIZE   = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  m_clk,
  input  logic                  m_write,
  input  logic [MEM_SIZE-1:0]   m_address,
  input  logic [DATA_WIDTH-1:0] m_in,
  output logic [DATA_WIDTH-1:0] m_out
);

  logic [DATA_WIDTH-1:0] mem [0:(2**MEM_SIZE)-1];

  always_ff @(posedge m_clk) begin
    if (m_write) mem[m_address] <= m_in;
    else         m_out          <= mem[m_address];
  end

endmodule

// File: rtl/mem_sequencer.sv
// READ/WRITE/FILL front-end driving a two-phase m_clk, 3 cycles per beat (accept to IDLE = 3N).
// req_ready only in IDLE: one command in flight, no back-to-back accept; READ data on a 1-cycle rsp_valid.
module mem_sequencer
  import mem_sequencer_pkg::*;
#(
  parameter int MEM_SIZE   = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [MEM_SIZE-1:0]   req_address,
  input  logic [DATA_WIDTH-1:0] req_data,
  input  logic [MEM_SIZE-1:0]   req_count,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  busy,
  output logic                  m_clk,
  output logic                  m_write,
  output logic [MEM_SIZE-1:0]   m_address,
  output logic [DATA_WIDTH-1:0] m_in,
  input  logic [DATA_WIDTH-1:0] m_out
);

  state_e              state;
  state_e              next_state;
  op_e                 cur_op;
  op_e                 in_op;
  logic [MEM_SIZE-1:0] beats;
  logic                accept;
  logic                start;
  logic                last_beat;

  assign in_op     = op_e'(req_op);
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = req_valid & req_ready;
  assign last_beat = (beats == MEM_SIZE'(1));

  // NOP and zero-length FILL are consumed in IDLE without touching the memory port.
  assign start = accept && ((in_op == OP_READ) || (in_op == OP_WRITE) ||
                            ((in_op == OP_FILL) && (req_count != '0)));

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = SETUP;
      SETUP:   next_state = HIGH;
      HIGH:    next_state = LOW;
      LOW:     next_state = last_beat ? IDLE : SETUP;
      default: next_state = IDLE;
    endcase
  end

  // m_clk is registered from next_state so the memory sees a clean single-cycle pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cur_op    <= OP_READ;
      beats     <= '0;
      m_clk     <= 1'b0;
      m_write   <= 1'b0;
      m_address <= '0;
      m_in      <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      state     <= next_state;
      m_clk     <= (next_state == HIGH);
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cur_op    <= in_op;
            m_address <= req_address;
            m_in      <= req_data;
            m_write   <= (in_op != OP_READ);
            beats     <= (in_op == OP_FILL) ? req_count : MEM_SIZE'(1);
          end
        end
        LOW: begin
          beats <= beats - MEM_SIZE'(1);
          if (cur_op == OP_READ) begin
            rsp_data  <= m_out;
            rsp_valid <= 1'b1;
          end
          if (!last_beat) m_address <= m_address + MEM_SIZE'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
